// File: rtl/smart_store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smart_store_pkg
// Description : Shared types and constants for the checkout scanner fabric:
//               arbiter state encoding, lookup status codes, data widths and
//               a saturating total accumulator helper.
// Revision    : 1.0 - initial release
// ============================================================================
package smart_store_pkg;

    localparam int TOTAL_W   = 14;
    localparam int PRICE_W   = 10;
    localparam int BARCODE_W = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    localparam logic [1:0] ST_ADDED   = 2'b00;
    localparam logic [1:0] ST_UNKNOWN = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_INVALID = 2'b11;

    // Adds a zero-extended price to a running total, clamping at all-ones.
    function automatic logic [TOTAL_W-1:0] sat_add(
        input logic [TOTAL_W-1:0] total,
        input logic [PRICE_W-1:0] price
    );
        logic [TOTAL_W:0] sum;
        sum = {1'b0, total} + {{(TOTAL_W + 1 - PRICE_W){1'b0}}, price};
        return sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant. The search starts at the
//               lane after ptr (the last granted lane) and wraps around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] grant
);

    logic [PTR_W-1:0] w_idx;

    // Walk from the farthest lane back to the nearest; the nearest requester wins.
    always_comb begin
        grant = '0;
        w_idx = '0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            w_idx = PTR_W'((int'(ptr) + k) % NUM_LANES);
            if (req[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : scan_arbiter
// Description : Shares one price-lookup port between NUM_LANES scanner lanes.
//               One transaction at a time: grant, issue lookup, wait for the
//               response (or time out), then update the lane total and ack.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_arbiter
    import smart_store_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_LANES-1:0]           lane_req,
    input  logic [BARCODE_W*NUM_LANES-1:0] lane_barcode,
    input  logic [NUM_LANES-1:0]           lane_clear,
    output logic [NUM_LANES-1:0]           lane_ack,
    output logic [1:0]                     ack_status,
    output logic [TOTAL_W*NUM_LANES-1:0]   lane_total,
    output logic                           pl_req,
    output logic [BARCODE_W-1:0]           pl_barcode,
    input  logic                           pl_valid,
    input  logic                           pl_hit,
    input  logic [PRICE_W-1:0]             pl_price,
    output logic                           busy
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                 r_state;
    logic [PTR_W-1:0]       r_last;
    logic [NUM_LANES-1:0]   r_grant;
    logic [1:0]             r_status;
    logic [PRICE_W-1:0]     r_price;
    logic [CNT_W-1:0]       r_tmo;
    logic                   r_pl_req;
    logic [BARCODE_W-1:0]   r_pl_barcode;
    logic [NUM_LANES-1:0]   r_lane_ack;
    logic [1:0]             r_ack_status;

    logic [NUM_LANES-1:0]   w_req_eff;
    logic [NUM_LANES-1:0]   w_grant;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [BARCODE_W-1:0]   w_sel_barcode;
    logic                   w_add;

    // A lane whose ack is on the wire this cycle is finished; its request may
    // still be high until the requester reacts, so keep it out of arbitration.
    assign w_req_eff = lane_req & ~r_lane_ack;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_rr (
        .req   (w_req_eff),
        .ptr   (r_last),
        .grant (w_grant)
    );

    // One-hot grant to lane index.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_grant[i]) w_grant_idx = PTR_W'(i);
        end
    end

    // Barcode of the lane currently being serviced.
    always_comb begin
        w_sel_barcode = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_last == PTR_W'(i)) w_sel_barcode = lane_barcode[BARCODE_W*i +: BARCODE_W];
        end
    end

    // Transaction sequencer with registered lookup and ack outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last       <= PTR_W'(NUM_LANES - 1);
            r_grant      <= '0;
            r_status     <= ST_ADDED;
            r_price      <= '0;
            r_tmo        <= '0;
            r_pl_req     <= 1'b0;
            r_pl_barcode <= '0;
            r_lane_ack   <= '0;
            r_ack_status <= '0;
        end else begin
            r_pl_req     <= 1'b0;
            r_lane_ack   <= '0;
            r_ack_status <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|w_req_eff) begin
                        r_grant <= w_grant;
                        r_last  <= w_grant_idx;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_pl_barcode <= w_sel_barcode;
                    r_tmo        <= '0;
                    if (w_sel_barcode != '0) begin
                        r_pl_req <= 1'b1;
                        r_state  <= S_WAIT;
                    end else begin
                        r_status <= ST_INVALID;
                        r_state  <= S_UPDATE;
                    end
                end
                S_WAIT: begin
                    if (pl_valid) begin
                        r_status <= pl_hit ? ST_ADDED : ST_UNKNOWN;
                        r_price  <= pl_price;
                        r_state  <= S_UPDATE;
                    end else if (r_tmo == CNT_W'(TIMEOUT - 1)) begin
                        r_status <= ST_TIMEOUT;
                        r_state  <= S_UPDATE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_lane_ack   <= r_grant;
                    r_ack_status <= r_status;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_add = (r_state == S_UPDATE) && (r_status == ST_ADDED);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [TOTAL_W-1:0] r_total;

        // Per-lane total: clear beats a same-cycle accumulate.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_total <= '0;
            end else if (lane_clear[g]) begin
                r_total <= '0;
            end else if (w_add && r_grant[g]) begin
                r_total <= sat_add(r_total, r_price);
            end
        end

        assign lane_total[TOTAL_W*g +: TOTAL_W] = r_total;
    end

    assign lane_ack   = r_lane_ack;
    assign ack_status = r_ack_status;
    assign pl_req     = r_pl_req;
    assign pl_barcode = r_pl_barcode;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_arbiter
// Description : Self-checking bench for scan_arbiter: scoreboard of expected
//               acks and lane totals plus directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_arbiter;
    import smart_store_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [N-1:0]    lane_req = '0;
    logic [16*N-1:0] lane_barcode = '0;
    logic [N-1:0]    lane_clear = '0;
    logic [N-1:0]    lane_ack;
    logic [1:0]      ack_status;
    logic [14*N-1:0] lane_total;
    logic            pl_req;
    logic [15:0]     pl_barcode;
    logic            pl_valid = 1'b0;
    logic            pl_hit = 1'b0;
    logic [9:0]      pl_price = '0;
    logic            busy;

    scan_arbiter #(.NUM_LANES(N), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .lane_req(lane_req), .lane_barcode(lane_barcode),
        .lane_clear(lane_clear), .lane_ack(lane_ack), .ack_status(ack_status),
        .lane_total(lane_total), .pl_req(pl_req), .pl_barcode(pl_barcode),
        .pl_valid(pl_valid), .pl_hit(pl_hit), .pl_price(pl_price), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lane;
        logic [15:0] barcode;
        logic [1:0] status;
        int         price;
    } exp_t;

    exp_t exp_q[$];
    int   exp_total[N];
    int   ack_cyc[N];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   req_cyc = 0;
    int   n_plreq = 0;
    logic [N-1:0] clr_edge = '0;

    // Lookup responder controls
    logic resp_never = 1'b0;
    logic resp_hit = 1'b1;
    logic [9:0] resp_price = '0;
    int   resp_delay = 0;
    int   resp_cnt = -1;
    int   late_cnt = 0;
    int   late_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        clr_edge <= lane_clear;
    end

    // Lookup model: answers resp_delay cycles after seeing pl_req, or never.
    always @(negedge clk) begin
        pl_valid = 1'b0;
        if (!reset_n) resp_cnt = -1;
        else if (pl_req && !resp_never) resp_cnt = resp_delay;
        if (late_cnt != late_done) begin
            late_done = late_cnt;
            pl_valid  = 1'b1;
            pl_hit    = 1'b1;
            pl_price  = 10'd100;
        end else if (resp_cnt == 0) begin
            pl_valid = 1'b1;
            pl_hit   = resp_hit;
            pl_price = resp_price;
            resp_cnt = -1;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
        end
    end

    // Scoreboard: acks in expected order, lookup barcodes, and all totals every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) exp_total[i] = 0;
            exp_q.delete();
            chk("rst_ctrl_outputs", {24'b0, lane_ack, ack_status, pl_req, busy}, 32'd0);
            chk("rst_pl_barcode", {16'b0, pl_barcode}, 32'd0);
            for (int i = 0; i < N; i++) chk("rst_total", {18'b0, lane_total[14*i +: 14]}, 32'd0);
        end else begin
            if (pl_req) begin
                n_plreq++;
                if (exp_q.size() == 0) chk("unexpected_pl_req", {31'b0, pl_req}, 32'd0);
                else begin
                    chk("pl_barcode", {16'b0, pl_barcode}, {16'b0, exp_q[0].barcode});
                    if (exp_q[0].status == ST_INVALID) chk("pl_req_on_zero_barcode", {31'b0, pl_req}, 32'd0);
                end
            end
            if (lane_ack != '0) begin
                if (exp_q.size() == 0) chk("unexpected_ack", {28'b0, lane_ack}, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("ack_lane", {28'b0, lane_ack}, 32'(1 << e.lane));
                    chk("ack_status", {30'b0, ack_status}, {30'b0, e.status});
                    ack_cyc[e.lane] = cyc;
                    if (e.status == ST_ADDED) begin
                        exp_total[e.lane] = exp_total[e.lane] + e.price;
                        if (exp_total[e.lane] > 16383) exp_total[e.lane] = 16383;
                    end
                end
            end
            for (int i = 0; i < N; i++) if (clr_edge[i]) exp_total[i] = 0;
            for (int i = 0; i < N; i++) chk("lane_total", {18'b0, lane_total[14*i +: 14]}, 32'(exp_total[i]));
        end
    end

    task automatic tick();
        @(negedge clk);
        lane_req = lane_req & ~lane_ack;
    endtask

    task automatic push(input int lane, input logic [15:0] bc, input logic [1:0] st, input int price);
        exp_t e;
        e.lane = lane; e.barcode = bc; e.status = st; e.price = price;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d acks outstanding after %0d cycles, want 0", exp_q.size(), budget);
            exp_q.delete();
            lane_req = '0;
        end
        tick();
    endtask

    task automatic do_txn(input int lane, input logic [15:0] bc, input logic [1:0] st, input int price);
        push(lane, bc, st, price);
        resp_hit   = (st == ST_ADDED);
        resp_price = 10'(price);
        @(posedge clk); #1;
        lane_barcode[lane*16 +: 16] = bc;
        lane_req[lane] = 1'b1;
        req_cyc = cyc;
        wait_drain(80);
    endtask

    task automatic pulse_clear(input int lane);
        @(posedge clk); #1;
        lane_clear[lane] = 1'b1;
        @(posedge clk); #1;
        lane_clear = '0;
        tick();
    endtask

    task automatic build_16300();
        pulse_clear(1);
        for (int k = 0; k < 16; k++) do_txn(1, 16'h5A5A, ST_ADDED, 1000);
        do_txn(1, 16'h5A5A, ST_ADDED, 300);
        chk("t5_total1_16300", {18'b0, lane_total[14 +: 14]}, 32'd16300);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset_n  = 1'b0;
        lane_req = '0;
        tick(); tick();
        #2 reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, want finish before 300000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int snap;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_pl_req", {31'b0, pl_req}, 32'd0);
        chk("reset_lane_ack", {28'b0, lane_ack}, 32'd0);
        chk("reset_total0", {18'b0, lane_total[0 +: 14]}, 32'd0);
        @(negedge clk); #2 reset_n = 1'b1;
        tick();

        // Single 0-wait hit on lane 0
        do_txn(0, 16'hF0F0, ST_ADDED, 250);
        chk("t1_latency", 32'(ack_cyc[0] - req_cyc), 32'd4);
        chk("t1_total0", {18'b0, lane_total[0 +: 14]}, 32'd250);
        chk("t1_busy_after", {31'b0, busy}, 32'd0);

        // All four lanes at once, fresh round-robin pointer
        do_reset();
        resp_hit = 1'b1; resp_price = 10'd10;
        for (int i = 0; i < N; i++) push(i, 16'h1000 + 16'(i), ST_ADDED, 10);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            lane_barcode[i*16 +: 16] = 16'h1000 + 16'(i);
            lane_req[i] = 1'b1;
        end
        wait_drain(80);
        for (int i = 0; i < N; i++) chk("t2_total_10", {18'b0, lane_total[14*i +: 14]}, 32'd10);
        push(1, 16'h1001, ST_ADDED, 10);
        push(3, 16'h1003, ST_ADDED, 10);
        @(posedge clk); #1;
        lane_req[1] = 1'b1; lane_req[3] = 1'b1;
        wait_drain(80);
        chk("t2_order_1_before_3", {31'b0, ack_cyc[1] < ack_cyc[3]}, 32'd1);
        chk("t2_total1_20", {18'b0, lane_total[14 +: 14]}, 32'd20);
        chk("t2_total3_20", {18'b0, lane_total[42 +: 14]}, 32'd20);

        // Zero barcode: no lookup, invalid status
        snap = n_plreq;
        do_txn(2, 16'h0000, ST_INVALID, 0);
        chk("t3_no_pl_req", 32'(n_plreq - snap), 32'd0);
        chk("t3_latency", 32'(ack_cyc[2] - req_cyc), 32'd3);
        chk("t3_total2", {18'b0, lane_total[28 +: 14]}, 32'd10);

        // Unknown item answered after two extra wait cycles
        resp_delay = 2;
        do_txn(3, 16'h0BAD, ST_UNKNOWN, 0);
        resp_delay = 0;
        chk("t3b_latency", 32'(ack_cyc[3] - req_cyc), 32'd6);
        chk("t3b_total3", {18'b0, lane_total[42 +: 14]}, 32'd20);

        // Lookup never answers, then a stray response arrives
        resp_never = 1'b1;
        do_txn(0, 16'h1234, ST_TIMEOUT, 0);
        chk("t4_latency", 32'(ack_cyc[0] - req_cyc), 32'd18);
        late_cnt++;
        repeat (4) tick();
        chk("t4_total0_unchanged", {18'b0, lane_total[0 +: 14]}, 32'd10);
        chk("t4_busy_idle", {31'b0, busy}, 32'd0);
        resp_never = 1'b0;

        // Saturation, then clear colliding with the update
        build_16300();
        do_txn(1, 16'h5A5A, ST_ADDED, 1000);
        chk("t5_saturated", {18'b0, lane_total[14 +: 14]}, 32'd16383);
        build_16300();
        push(1, 16'h5A5A, ST_ADDED, 1000);
        resp_hit = 1'b1; resp_price = 10'd1000;
        @(posedge clk); #1;
        lane_req[1] = 1'b1;
        req_cyc = cyc;
        repeat (3) @(posedge clk);
        #1 lane_clear[1] = 1'b1;
        @(posedge clk);
        #1 lane_clear = '0;
        wait_drain(80);
        chk("t5_collision_latency", 32'(ack_cyc[1] - req_cyc), 32'd4);
        chk("t5_collision_total1", {18'b0, lane_total[14 +: 14]}, 32'd0);

        // Reset in the middle of a lookup wait
        resp_never = 1'b1;
        push(2, 16'hC0DE, ST_ADDED, 5);
        @(posedge clk); #1;
        lane_barcode[32 +: 16] = 16'hC0DE;
        lane_req[2] = 1'b1;
        n = 0;
        while (!pl_req && n < 10) begin
            tick();
            n++;
        end
        chk("t6_pl_req_seen", {31'b0, pl_req}, 32'd1);
        chk("t6_busy_in_wait", {31'b0, busy}, 32'd1);
        tick();
        #2 reset_n = 1'b0;
        lane_req = '0;
        #1;
        chk("t6_rst_busy", {31'b0, busy}, 32'd0);
        chk("t6_rst_pl_barcode", {16'b0, pl_barcode}, 32'd0);
        chk("t6_rst_pl_req", {31'b0, pl_req}, 32'd0);
        chk("t6_rst_total1", {18'b0, lane_total[14 +: 14]}, 32'd0);
        tick(); tick();
        #2 reset_n = 1'b1;
        late_cnt++;
        repeat (20) tick();
        chk("t6_idle_after", {31'b0, busy}, 32'd0);
        resp_never = 1'b0;
        push(0, 16'h0A0A, ST_ADDED, 77);
        push(3, 16'h0B0B, ST_ADDED, 77);
        resp_hit = 1'b1; resp_price = 10'd77;
        @(posedge clk); #1;
        lane_barcode[0 +: 16]  = 16'h0A0A;
        lane_barcode[48 +: 16] = 16'h0B0B;
        lane_req[0] = 1'b1; lane_req[3] = 1'b1;
        req_cyc = cyc;
        wait_drain(80);
        chk("t6_latency_lane0", 32'(ack_cyc[0] - req_cyc), 32'd4);
        chk("t6_total0", {18'b0, lane_total[0 +: 14]}, 32'd77);
        chk("t6_total3", {18'b0, lane_total[42 +: 14]}, 32'd77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_arbiter.md
SCAN_ARBITER -- requirements
Module: scan_arbiter

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of scanner lanes (carts) sharing one price lookup.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum cycles to wait for a lookup response.
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port lane_req  in  NUM_LANES  per-lane scan request, held high until its lane_ack.
REQ-006 SHALL have port lane_barcode  in  16*NUM_LANES  per-lane barcode, lane i at bits [16i+15:16i], stable while lane_req[i] is high.
REQ-007 SHALL have port lane_clear  in  NUM_LANES  per-lane total clear, at checkout.
REQ-008 SHALL have port lane_ack  out  NUM_LANES  one-cycle completion pulse, one-hot or zero.
REQ-009 SHALL have port ack_status  out  2  result qualified by lane_ack: 00 added, 01 unknown item, 10 timeout, 11 invalid barcode.
REQ-010 SHALL have port lane_total  out  14*NUM_LANES  per-lane running cost total.
REQ-011 SHALL have port pl_req  out  1  lookup request, single-cycle pulse.
REQ-012 SHALL have port pl_barcode  out  16  barcode presented to the lookup, held from pl_req until the transaction closes.
REQ-013 SHALL have port pl_valid  in  1  lookup response strobe.
REQ-014 SHALL have port pl_hit  in  1  item known, qualified by pl_valid.
REQ-015 SHALL have port pl_price  in  10  item cost, qualified by pl_valid and pl_hit.
REQ-016 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> UPDATE -> IDLE.
REQ-018 SHALL, in IDLE with any lane_req set, grant round-robin starting at the lane after the last granted lane (lane 0 first after reset) and go to ISSUE.
REQ-019 SHALL, in ISSUE, latch the granted barcode onto pl_barcode.
REQ-020 SHALL, in ISSUE, pulse pl_req and go to WAIT when the barcode is nonzero.
REQ-021 SHALL, in ISSUE with barcode 16'h0000, skip the lookup and go to UPDATE with status 11.
REQ-022 SHALL, in WAIT, go to UPDATE when pl_valid is seen: status 00 when pl_hit is 1, 01 when pl_hit is 0.
REQ-023 SHALL, in WAIT with no pl_valid after TIMEOUT cycles, go to UPDATE with status 10.
REQ-024 SHALL ignore pl_valid arriving outside WAIT.
REQ-025 SHALL, in UPDATE, add zero-extended pl_price to the granted lane total only for status 00.
REQ-026 SHALL saturate each total at 14'h3FFF.
REQ-027 SHALL pulse lane_ack for the granted lane and drive ack_status in the UPDATE cycle, then return to IDLE.
REQ-028 SHALL give a 0-wait-state lookup (pl_valid in the first WAIT cycle) a latency of 4 cycles from req sampled in IDLE to lane_ack.
REQ-029 SHALL service at most one transaction at a time; other lanes wait.
REQ-030 SHALL let lane_clear[i] zero total i in the next cycle, in any state.
REQ-031 SHALL give lane_clear priority over a same-cycle UPDATE to the same lane: the total becomes 0 and the ack still issues with its status.
REQ-032 SHALL, when a lane drops lane_req before its ack, still complete the transaction and pulse lane_ack.

Reset
REQ-033 SHALL, while reset_n is low, asynchronously force state IDLE, all totals to 0, the round-robin pointer to the last lane (so lane 0 wins next), and pl_req, lane_ack, ack_status, pl_barcode, busy and the timeout counter to 0.
REQ-034 SHALL, on reset mid-transaction, abandon the transaction with no ack and ignore any later pl_valid.

Structure
REQ-035 SHALL keep the FSM state encoding, status codes (ST_ADDED, ST_UNKNOWN, ST_TIMEOUT, ST_INVALID), TOTAL_W=14 and PRICE_W=10 in package smart_store_pkg.
REQ-036 SHALL implement the round-robin grant as sub-module rr_arbiter (req vector and pointer in, one-hot grant out, combinational).

Verification
REQ-037 SHALL cover: lane 0 barcode 16'hF0F0, lookup answers next cycle with hit and price 250 -> lane_ack[0] 4 cycles after req, status 00, total0 = 250.
REQ-038 SHALL cover: lanes 0-3 requesting simultaneously, all lookups hit with price 10 -> acks in order 0,1,2,3, each total 10; then lanes 1 and 3 re-request -> grant order 1 then 3.
REQ-039 SHALL cover: lane 2 barcode 16'h0000 -> no pl_req, status 11, total2 unchanged.
REQ-040 SHALL cover: lookup never responds -> status 10 after 15 WAIT cycles; a late pl_valid is ignored.
REQ-041 SHALL cover: total1 = 16300 plus price 1000 -> total1 = 16383; lane_clear[1] in the same UPDATE cycle -> total1 = 0, ack still issued.
REQ-042 SHALL cover: reset_n asserted low during WAIT -> all outputs 0 immediately, no ack after release, and the next request is serviced normally.
